// File: rtl/param_cpu_core_if.sv
// param_cpu_core_if
//   Bus bundle between the core and its surroundings: the instruction ROM
//   read port and the din/dout handshake to the board I/O.
//   master : the core (drives imem_addr, din_ready, dout, dout_valid)
//   slave  : ROM / I/O side (drives imem_rdata, din, din_valid)
//   Parameters: DW (data width), PC_W (instruction address width).
interface param_cpu_core_if #(
  parameter int DW   = 16,
  parameter int PC_W = 4
);
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [DW-1:0]   din;
  logic            din_valid;
  logic            din_ready;
  logic [DW-1:0]   dout;
  logic            dout_valid;

  modport master (
    output imem_addr, din_ready, dout, dout_valid,
    input  imem_rdata, din, din_valid
  );

  modport slave (
    input  imem_addr, din_ready, dout, dout_valid,
    output imem_rdata, din, din_valid
  );
endinterface

// File: rtl/param_cpu_core.sv
// param_cpu_core
//   Multi-cycle processor core: FETCH -> LOAD -> EXEC, 3 cycles per
//   instruction (storedin stalls in EXEC until din_valid). External ROM with
//   a registered 1-cycle read; register file, SGPR and data memory inside.
//   Ports:
//     clk, sys_rst_n  clock, asynchronous active-low reset
//     start           pulse: leave IDLE/HALT and run from PC=0
//     step            (CPU_SINGLE_STEP_EN only) retire one instruction per pulse
//     bus             param_cpu_core_if.master (imem read, din/dout handshake)
//     flags           {sign, zero, carry, overflow}
//     halted          high while in HALT
//   Build option: define CPU_SINGLE_STEP_EN to add the step input and the
//   STEP_WAIT state between instructions.
//   IR layout: [31:27] op, [26:22] rdst, [21:17] rsrc1, [16] imm,
//              [15:11] rsrc2, [15:0] isrc.
module param_cpu_core #(
  parameter int DW         = 16,
  parameter int NREG       = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  localparam int PC_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1,
  localparam int DA_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1,
  localparam int RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                    clk,
  input  logic                    sys_rst_n,
  input  logic                    start,
`ifdef CPU_SINGLE_STEP_EN
  input  logic                    step,
`endif
  param_cpu_core_if.master        bus,
  output logic [3:0]              flags,
  output logic                    halted
);

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rdst;
    logic [4:0]  rsrc1;
    logic        imm;
    logic [15:0] isrc;
  } instr_t;

  localparam logic [4:0] OP_MOVSGPR = 5'b00000, OP_MOV  = 5'b00001,
                         OP_ADD     = 5'b00010, OP_SUB  = 5'b00011,
                         OP_MUL     = 5'b00100, OP_OR   = 5'b00101,
                         OP_AND     = 5'b00110, OP_XOR  = 5'b00111,
                         OP_XNOR    = 5'b01000, OP_NAND = 5'b01001,
                         OP_NOR     = 5'b01010, OP_NOT  = 5'b01011,
                         OP_STOREREG = 5'b01101, OP_STOREDIN = 5'b01110,
                         OP_SENDDOUT = 5'b01111, OP_SENDREG  = 5'b10001,
                         OP_JMP = 5'b10010, OP_JC  = 5'b10011, OP_JNC = 5'b10100,
                         OP_JS  = 5'b10101, OP_JNS = 5'b10110, OP_JZ  = 5'b10111,
                         OP_JNZ = 5'b11000, OP_JV  = 5'b11001, OP_JNV = 5'b11010,
                         OP_HALT = 5'b11011;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_HALT, S_STEP} state_t;

`ifdef CPU_SINGLE_STEP_EN
  localparam state_t S_GO = S_STEP;   // park between instructions
`else
  localparam state_t S_GO = S_FETCH;
`endif

  state_t state, nxt;

  logic [PC_W-1:0] pc, pc_inc, pc_nxt;
  instr_t          ir;
  logic [DW-1:0]   gpr [NREG];
  logic [DW-1:0]   sgpr;
  logic [DW-1:0]   dmem [DMEM_DEPTH];
  logic [DW-1:0]   dout_r;
  logic            dout_vld;

  logic [RW-1:0]   rd_i, rs1_i, rs2_i;
  logic [DA_W-1:0] daddr;
  logic [DW-1:0]   isrc_x, a, b, alu_res;
  logic [DW:0]     sum;
  logic [DW-1:0]   diff;
  logic [2*DW-1:0] prod;
  logic [3:0]      alu_flags;
  logic            is_alu, take;
  logic            start_go, load_ir, exec_fire, din_rdy;

  assign rd_i   = ir.rdst[RW-1:0];
  assign rs1_i  = ir.rsrc1[RW-1:0];
  assign rs2_i  = ir.isrc[15:11];
  assign daddr  = ir.isrc[DA_W-1:0];
  assign isrc_x = DW'(ir.isrc);
  assign a      = gpr[rs1_i];
  assign b      = ir.imm ? isrc_x : gpr[rs2_i];
  assign is_alu = (ir.op <= OP_NOT);

  assign bus.imem_addr  = pc;
  assign bus.din_ready  = din_rdy;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_vld;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) nxt = S_GO;
`ifdef CPU_SINGLE_STEP_EN
      S_STEP:         if (!start && step) nxt = S_FETCH;
`endif
      S_FETCH:        nxt = S_LOAD;
      S_LOAD:         nxt = S_EXEC;
      S_EXEC: begin
        if (ir.op == OP_HALT)                              nxt = S_HALT;
        else if (ir.op == OP_STOREDIN && !bus.din_valid)   nxt = S_EXEC;
        else                                               nxt = S_GO;
      end
      default:        nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    halted    = (state == S_HALT);
    din_rdy   = (state == S_EXEC) && (ir.op == OP_STOREDIN);
    load_ir   = (state == S_LOAD);
    exec_fire = (state == S_EXEC) && !(din_rdy && !bus.din_valid);
    start_go  = start && ((state == S_IDLE) || (state == S_HALT));
`ifdef CPU_SINGLE_STEP_EN
    if (state == S_STEP && start) start_go = 1'b1;
`endif
  end

  // ---------------- ALU ----------------
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = a - b;
    prod      = (2*DW)'(a) * (2*DW)'(b);
    alu_res   = '0;
    alu_flags = '0;
    case (ir.op)
      OP_MOVSGPR: alu_res = sgpr;
      OP_MOV:     alu_res = ir.imm ? isrc_x : a;
      OP_ADD: begin
        alu_res      = sum[DW-1:0];
        alu_flags[1] = sum[DW];
        alu_flags[0] = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        alu_res      = diff;
        alu_flags[0] = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      OP_MUL:     alu_res = prod[DW-1:0];
      OP_OR:      alu_res = a | b;
      OP_AND:     alu_res = a & b;
      OP_XOR:     alu_res = a ^ b;
      OP_XNOR:    alu_res = ~(a ^ b);
      OP_NAND:    alu_res = ~(a & b);
      OP_NOR:     alu_res = ~(a | b);
      OP_NOT:     alu_res = ir.imm ? ~isrc_x : ~a;
      default:    alu_res = '0;
    endcase
    // mul reports sign/zero on the full double-width product
    if (ir.op == OP_MUL) begin
      alu_flags[3] = prod[2*DW-1];
      alu_flags[2] = (prod == '0);
    end else begin
      alu_flags[3] = alu_res[DW-1];
      alu_flags[2] = (alu_res == '0);
    end
  end

  // ---------------- next PC ----------------
  always_comb begin
    case (ir.op)
      OP_JMP:  take = 1'b1;
      OP_JC:   take =  flags[1];
      OP_JNC:  take = !flags[1];
      OP_JS:   take =  flags[3];
      OP_JNS:  take = !flags[3];
      OP_JZ:   take =  flags[2];
      OP_JNZ:  take = !flags[2];
      OP_JV:   take =  flags[0];
      OP_JNV:  take = !flags[0];
      default: take = 1'b0;
    endcase
    pc_inc = (pc == PC_W'(IMEM_DEPTH - 1)) ? '0 : pc + PC_W'(1);
    if (ir.op == OP_HALT) pc_nxt = pc;
    else if (take)        pc_nxt = ir.isrc[PC_W-1:0];
    else                  pc_nxt = pc_inc;
  end

  // ---------------- architectural state ----------------
  // Every result lands on the edge that ends EXEC, so all reads in EXEC see
  // the pre-instruction register values.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pc       <= '0;
      ir       <= '0;
      sgpr     <= '0;
      flags    <= '0;
      dout_r   <= '0;
      dout_vld <= 1'b0;
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else begin
      dout_vld <= 1'b0;
      if (start_go) pc <= '0;
      if (load_ir)  ir <= instr_t'(bus.imem_rdata);
      if (exec_fire) begin
        pc <= pc_nxt;
        if (is_alu) begin
          gpr[rd_i] <= alu_res;
          flags     <= alu_flags;
        end
        if (ir.op == OP_MUL)     sgpr <= prod[2*DW-1:DW];
        if (ir.op == OP_SENDREG) gpr[rd_i] <= dmem[daddr];
        if (ir.op == OP_SENDDOUT) begin
          dout_r   <= dmem[daddr];
          dout_vld <= 1'b1;
        end
      end
    end
  end

  // Data memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (exec_fire && ir.op == OP_STOREREG) dmem[daddr] <= a;
    if (exec_fire && ir.op == OP_STOREDIN) dmem[daddr] <= bus.din;
  end

endmodule

// File: tb/tb_param_cpu_core.sv
// tb_param_cpu_core
//   Drives programs through a registered ROM model, feeds din with random
//   delays, and compares dout stream, flags, final PC, cycle count and
//   register contents against an instruction-level reference model.
module tb_param_cpu_core;
  localparam logic [4:0] OMOVS = 5'd0, OMOV = 5'd1, OADD = 5'd2, OSUB = 5'd3, OMUL = 5'd4,
                         OSTR = 5'd13, OSDIN = 5'd14, OSOUT = 5'd15, OSREG = 5'd17,
                         OJMP = 5'd18, OJZ = 5'd23, OJNZ = 5'd24, OJC = 5'd19, OHALT = 5'd27,
                         ONOP0 = 5'd12, ONOP1 = 5'd16;

  logic clk = 1'b0;
  logic sys_rst_n, start;
  logic [3:0] flags;
  logic halted;
`ifdef CPU_SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  param_cpu_core_if #(.DW(16), .PC_W(4)) bus ();

  param_cpu_core dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .start(start),
`ifdef CPU_SINGLE_STEP_EN
    .step(step),
`endif
    .bus(bus), .flags(flags), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [16];
  always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

  int n_chk = 0, n_fail = 0;
  int cyc, stall, pk;
  logic [15:0] din_q [$];
  logic [15:0] exp_q [$];
  logic [15:0] got_q [$];
  int exp_n;

  // reference model state
  logic [15:0] m_gpr [32];
  logic [15:0] m_dmem [16];
  logic [15:0] m_sgpr;
  logic [3:0]  m_flags;
  int          m_pc;

  logic [15:0] spec_v [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0100};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic im, input logic [15:0] src);
    return {op, rd, rs, im, src};
  endfunction

  function automatic logic [15:0] rr(input logic [4:0] r2);
    return {r2, 11'd0};
  endfunction

  function automatic int sx(input logic [15:0] x);
    return x[15] ? int'(x) - 65536 : int'(x);
  endfunction

  task automatic clr();
    for (int i = 0; i < 16; i++) rom[i] = {OHALT, 27'd0};
    pk = 0;
  endtask

  task automatic put(input logic [31:0] w);
    rom[pk] = w;
    pk++;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 16'h0;
    m_sgpr = 16'h0; m_flags = 4'h0; m_pc = 0;
  endtask

  // Instruction-level model: runs the ROM from PC 0 until halt.
  task automatic iss();
    int n, di, u, ss;
    logic [31:0] w; logic [4:0] op; logic [15:0] a, b, is, res;
    logic c, v, tk; bit done; longint p;
    exp_q.delete(); n = 0; di = 0; m_pc = 0; done = 0;
    while (!done && n < 100) begin
      w = rom[m_pc]; n++;
      op = w[31:27]; is = w[15:0];
      a = m_gpr[w[21:17]];
      b = w[16] ? is : m_gpr[is[15:11]];
      res = 16'h0; c = 1'b0; v = 1'b0; tk = 1'b0; p = 0;
      case (op)
        5'd0:  res = m_sgpr;
        5'd1:  res = w[16] ? is : a;
        5'd2: begin
          u = int'(a) + int'(b); res = u[15:0]; c = (u > 65535);
          ss = sx(a) + sx(b); v = (ss > 32767) || (ss < -32768);
        end
        5'd3: begin
          u = int'(a) - int'(b); res = u[15:0];
          ss = sx(a) - sx(b); v = (ss > 32767) || (ss < -32768);
        end
        5'd4: begin
          p = longint'(a) * longint'(b); res = p[15:0]; m_sgpr = p[31:16];
        end
        5'd5:  res = a | b;
        5'd6:  res = a & b;
        5'd7:  res = a ^ b;
        5'd8:  res = ~(a ^ b);
        5'd9:  res = ~(a & b);
        5'd10: res = ~(a | b);
        5'd11: res = w[16] ? ~is : ~a;
        5'd13: m_dmem[is[3:0]] = a;
        5'd14: begin m_dmem[is[3:0]] = din_q[di]; di++; end
        5'd15: exp_q.push_back(m_dmem[is[3:0]]);
        5'd17: m_gpr[w[26:22]] = m_dmem[is[3:0]];
        5'd18: tk = 1'b1;
        5'd19: tk =  m_flags[1];
        5'd20: tk = !m_flags[1];
        5'd21: tk =  m_flags[3];
        5'd22: tk = !m_flags[3];
        5'd23: tk =  m_flags[2];
        5'd24: tk = !m_flags[2];
        5'd25: tk =  m_flags[0];
        5'd26: tk = !m_flags[0];
        5'd27: done = 1;
        default: ;
      endcase
      if (op <= 5'd11) begin
        m_gpr[w[26:22]] = res;
        if (op == 5'd4) m_flags = {p[31], p == 0, 1'b0, 1'b0};
        else            m_flags = {res[15], res == 16'h0, c, v};
      end
      if (!done) m_pc = tk ? int'(is[3:0]) : (m_pc + 1) % 16;
    end
    exp_n = n;
  endtask

  // Run the loaded program on the DUT and compare it with the model.
  // fdly >= 0 forces the din delay, otherwise it is random.
  task automatic run(input string tg, input int fdly);
    int di, dly;
    iss();
    got_q.delete(); stall = 0; di = 0; dly = -1; cyc = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!halted && cyc < 400) begin
      @(negedge clk); cyc++;
      if (bus.dout_valid) got_q.push_back(bus.dout);
      if (bus.din_valid) begin
        bus.din_valid = 1'b0; di++; dly = -1;
      end else if (bus.din_ready) begin
        if (dly < 0) dly = (fdly >= 0) ? fdly : int'($urandom_range(0, 4));
        if (dly > 0) begin dly--; stall++; end
        else begin bus.din = din_q[di]; bus.din_valid = 1'b1; end
      end
    end
    chk({tg, "_timeout"}, 64'(cyc < 400), 64'(1));
    chk({tg, "_cycles"}, 64'(cyc), 64'(3 * exp_n + stall));
    chk({tg, "_flags"}, 64'(flags), 64'(m_flags));
    chk({tg, "_pc"}, 64'(bus.imem_addr), 64'(m_pc));
    chk({tg, "_ndout"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tg, "_dout"}, 64'(got_q[i]), 64'(exp_q[i]));
    for (int r = 0; r < 8; r++)
      chk({tg, "_gpr"}, 64'(dut.gpr[r]), 64'(m_gpr[r]));
    chk({tg, "_sgpr"}, 64'(dut.sgpr), 64'(m_sgpr));
  endtask

  initial begin
    sys_rst_n = 1'b0; start = 1'b0; bus.din = 16'h0; bus.din_valid = 1'b0;
    clr(); m_reset();
    repeat (3) @(negedge clk);
    chk("rst_halted", 64'(halted), 64'(0));
    chk("rst_flags", 64'(flags), 64'(0));
    chk("rst_dout", 64'(bus.dout), 64'(0));
    chk("rst_dvld", 64'(bus.dout_valid), 64'(0));
    chk("rst_drdy", 64'(bus.din_ready), 64'(0));
    chk("rst_pc", 64'(bus.imem_addr), 64'(0));
    sys_rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_pc", 64'(bus.imem_addr), 64'(0));
    chk("idle_halted", 64'(halted), 64'(0));

    // mov r1,#5 ; add r2,r1,#3 ; halt
    clr();
    put(enc(OMOV, 5'd1, 5'd0, 1'b1, 16'd5));
    put(enc(OADD, 5'd2, 5'd1, 1'b1, 16'd3));
    run("t1", 0);
    chk("t1_r2", 64'(dut.gpr[2]), 64'(16'd8));
    chk("t1_cyc", 64'(cyc), 64'(9));
    chk("t1_halted", 64'(halted), 64'(1));

    // signed overflow, then carry/zero
    clr();
    put(enc(OMOV, 5'd1, 5'd0, 1'b1, 16'h7FFF));
    put(enc(OADD, 5'd2, 5'd1, 1'b1, 16'd1));
    run("t2a", 0);
    chk("t2a_r2", 64'(dut.gpr[2]), 64'(16'h8000));
    chk("t2a_flags", 64'(flags), 64'(4'b1001));
    clr();
    put(enc(OMOV, 5'd3, 5'd0, 1'b1, 16'hFFFF));
    put(enc(OADD, 5'd4, 5'd3, 1'b1, 16'd1));
    run("t2b", 0);
    chk("t2b_r4", 64'(dut.gpr[4]), 64'(16'h0));
    chk("t2b_flags", 64'(flags), 64'(4'b0110));

    // mul high half to SGPR, read back with movsgpr
    clr();
    put(enc(OMOV, 5'd1, 5'd0, 1'b1, 16'h1234));
    put(enc(OMOV, 5'd2, 5'd0, 1'b1, 16'h0100));
    put(enc(OMUL, 5'd3, 5'd1, 1'b0, rr(5'd2)));
    put(enc(OMOVS, 5'd4, 5'd0, 1'b0, 16'h0));
    run("t3", 0);
    chk("t3_r3", 64'(dut.gpr[3]), 64'(16'h3400));
    chk("t3_r4", 64'(dut.gpr[4]), 64'(16'h0012));

    // PC wrap 15 -> 0 and undefined opcodes as NOP
    clr();
    put(enc(OJC, 5'd0, 5'd0, 1'b1, 16'd4));
    put(enc(OMOV, 5'd3, 5'd0, 1'b1, 16'hFFFF));
    put(enc(OJMP, 5'd0, 5'd0, 1'b1, 16'd14));
    rom[14] = enc(ONOP1, 5'd0, 5'd0, 1'b0, 16'h0);
    rom[15] = enc(OADD, 5'd5, 5'd3, 1'b1, 16'd1);
    rom[3]  = enc(ONOP0, 5'd0, 5'd0, 1'b0, 16'h0);
    run("wrap", 0);
    chk("wrap_pc", 64'(bus.imem_addr), 64'(4));
    chk("wrap_cyc", 64'(cyc), 64'(21));

    // zero flag, jnozero not taken, mov #0, jzero taken
    clr();
    put(enc(OSUB, 5'd5, 5'd1, 1'b0, rr(5'd1)));
    put(enc(OJNZ, 5'd0, 5'd0, 1'b1, 16'd7));
    put(enc(OMOV, 5'd6, 5'd0, 1'b1, 16'd0));
    put(enc(OJZ, 5'd0, 5'd0, 1'b1, 16'd7));
    put(enc(OMOV, 5'd7, 5'd0, 1'b1, 16'hAAAA));
    run("t4", 0);
    chk("t4_pc", 64'(bus.imem_addr), 64'(7));
    chk("t4_flags", 64'(flags), 64'(4'b0100));
    chk("t4_cyc", 64'(cyc), 64'(15));

    // storedin stalled 5 cycles, senddout, sendreg
    clr();
    din_q.delete(); din_q.push_back(16'hBEEF);
    put(enc(OSDIN, 5'd0, 5'd0, 1'b1, 16'd3));
    put(enc(OSOUT, 5'd0, 5'd0, 1'b1, 16'd3));
    put(enc(OSREG, 5'd6, 5'd0, 1'b1, 16'd3));
    run("t5", 5);
    chk("t5_cyc", 64'(cyc), 64'(17));
    chk("t5_n", 64'(got_q.size()), 64'(1));
    if (got_q.size() > 0) chk("t5_dout", 64'(got_q[0]), 64'(16'hBEEF));
    chk("t5_r6", 64'(dut.gpr[6]), 64'(16'hBEEF));

    // reset during EXEC of add
    clr();
    put(enc(OMOV, 5'd1, 5'd0, 1'b1, 16'd5));
    put(enc(OADD, 5'd2, 5'd1, 1'b1, 16'd3));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    sys_rst_n = 1'b0;
    @(negedge clk);
    chk("rx_r2", 64'(dut.gpr[2]), 64'(0));
    chk("rx_pc", 64'(bus.imem_addr), 64'(0));
    chk("rx_flags", 64'(flags), 64'(0));
    sys_rst_n = 1'b1; m_reset();
    repeat (4) @(negedge clk);
    chk("rx_idle_pc", 64'(bus.imem_addr), 64'(0));
    chk("rx_idle_r2", 64'(dut.gpr[2]), 64'(0));
    run("rx_rerun", 0);
    chk("rx_r2_final", 64'(dut.gpr[2]), 64'(16'd8));

    // random programs
    for (int t = 0; t < 30; t++) begin
      logic [15:0] src; logic [4:0] op;
      clr(); din_q.delete();
      din_q.push_back(16'($urandom));
      for (int s = 0; s < 6; s++) begin
        op  = 5'($urandom_range(0, 12));
        src = ($urandom_range(0, 1) == 1) ? spec_v[$urandom_range(0, 5)] : 16'($urandom);
        if ($urandom_range(0, 1) == 1)
          put(enc(op, 5'($urandom_range(1, 3)), 5'($urandom_range(0, 3)), 1'b1, src));
        else
          put(enc(op, 5'($urandom_range(1, 3)), 5'($urandom_range(0, 3)), 1'b0,
                  {5'($urandom_range(0, 3)), src[10:0]}));
      end
      put(enc(5'($urandom_range(18, 26)), 5'd0, 5'd0, 1'b1, 16'd8));
      put(enc(OADD, 5'd1, 5'd1, 1'b1, 16'd1));
      for (int r = 1; r <= 2; r++) begin
        src = 16'($urandom_range(0, 15));
        put(enc(OSTR, 5'd0, 5'(r), 1'b1, src));
        put(enc(OSOUT, 5'd0, 5'd0, 1'b1, src));
      end
      src = 16'($urandom_range(0, 15));
      put(enc(OSDIN, 5'd0, 5'd0, 1'b1, src));
      put(enc(OSOUT, 5'd0, 5'd0, 1'b1, src));
      run("rnd", -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
